pci_protocol_monitor: RTL and testbench
=======================================

Name: pci_protocol_monitor

Overview:
- Synthesizable PCI bus protocol monitor; the parametrised successor to the team's simulation-only PCI property checks.
- Passively taps FRAME_/IRDY_/TRDY_/DEVSEL_/C_BE_/AD and tracks bus phases with a state machine.
- Detects protocol violations, including a DEVSEL_ timeout.
- Exposes sticky error flags, a one-cycle error pulse and saturating transaction/data/error counters; sits beside the bus model in testbenches and in emulation builds.

Parameters:
AD_WIDTH, 32, address/data bus width; legal values 32 or 64.
CBE_WIDTH, AD_WIDTH/8, width of C_BE_.
DEVSEL_TIMEOUT, 5, maximum clocks from address phase to DEVSEL_ assertion; range 1..15.
CHECK_EN, 6'b111111, per-check enable mask; bit index = check ID.
CNT_WIDTH, 16, width of every counter.

Ports:
clk  in  1  bus clock; all sampling on posedge.
reset_  in  1  asynchronous, active-low reset.
FRAME_  in  1  PCI FRAME_, active low.
IRDY_  in  1  PCI IRDY_, active low.
TRDY_  in  1  PCI TRDY_, active low.
DEVSEL_  in  1  PCI DEVSEL_, active low.
C_BE_  in  CBE_WIDTH  command / byte enables.
AD  in  AD_WIDTH  address/data; monitored only to capture the address.
clr  in  1  synchronous clear of flags and counters.
bus_state  out  2  current phase (IDLE/ADDR/DATA/LAST).
err_flags  out  6  sticky violation flags, one per check ID.
err_pulse  out  1  high one cycle whenever any enabled check fires.
err_count  out  CNT_WIDTH  saturating count of cycles with at least one violation.
txn_count  out  CNT_WIDTH  saturating count of completed transactions.
data_count  out  CNT_WIDTH  saturating count of data transfers (IRDY_ and TRDY_ both low).
last_addr  out  AD_WIDTH  AD captured at the most recent address phase.
last_cmd  out  CBE_WIDTH  C_BE_ captured at the most recent address phase.

Behaviour:
- Reset (reset_ low, async):
  - All outputs 0; bus_state = IDLE.
  - Registered copies of FRAME_/IRDY_/TRDY_ reset to 1; C_BE_ copy reset to 0.
  - Timeout counter reset to 0.
- Edge helpers: fell_frame = prev FRAME_ high and FRAME_ low; rose_frame = prev FRAME_ low and FRAME_ high. xfer = !IRDY_ && !TRDY_.
- FSM, one transition per posedge:
  - IDLE -> ADDR on fell_frame; capture AD into last_addr and C_BE_ into last_cmd.
  - ADDR -> DATA unconditionally next cycle; clear timeout counter.
  - DATA -> LAST when FRAME_ is high.
  - LAST -> IDLE when xfer && FRAME_ high; increment txn_count.
  - DATA or LAST -> IDLE on timeout (check 3); txn_count not incremented.
  - fell_frame while in DATA or LAST: raise check 5, restart at ADDR.
- Timeout counter:
  - In DATA/LAST, increments each cycle while DEVSEL_ is high and DEVSEL_ has not yet been seen low in this transaction.
  - Check 3 fires when the counter reaches DEVSEL_TIMEOUT.
- Checks (ID: condition, evaluated on posedge samples):
  - 0: rose_frame && IRDY_ high.
  - 1: TRDY_ low && DEVSEL_ high.
  - 2: C_BE_ differs from the previous sample while in DATA/LAST, and the previous cycle had IRDY_ low and TRDY_ high (byte enables unstable across a wait state).
  - 3: DEVSEL_ timeout (master abort).
  - 4: IRDY_ rises in DATA/LAST while the previous cycle had IRDY_ low and no xfer.
  - 5: fell_frame while in DATA or LAST (no idle between transactions).
- Outputs:
  - err_pulse = OR of (fired & CHECK_EN), registered; visible the cycle after the violating sample.
  - err_flags[i] set on the same edge and held until clr or reset.
  - data_count increments on every xfer in DATA/LAST.
- Counters saturate at all-ones and never wrap.
- clr:
  - Zeroes err_flags, err_count, txn_count and data_count next edge; FSM unaffected.
  - If clr and a violation coincide, clr wins (flag stays 0 and pulse suppressed).
- Reset mid-transaction returns to IDLE; the next fell_frame starts a fresh transaction.

Decomposition:
- Package pci_mon_pkg: bus_state_e enum (IDLE=0, ADDR=1, DATA=2, LAST=3); check ID localparams CHK_FRM_IRDY=0 .. CHK_BACK2BACK=5; NUM_CHECKS=6.
- Sub-module pci_mon_sat_counter (parameter WIDTH; ports inc, clr, count), instantiated three times.

Test Plan:
- Single write: FRAME_ falls with AD=32'h1000_0040, C_BE_=4'h7; DEVSEL_ low next cycle; one xfer with FRAME_ high -> txn_count=1, data_count=1, last_addr=32'h1000_0040, last_cmd=4'h7, err_flags=0.
- Burst of 4 with 2 wait states, C_BE_ stable -> data_count=4, no errors. Repeat with C_BE_ changed 4'h0->4'h3 during a wait -> err_flags[2]=1, err_pulse exactly 1 cycle, err_count=1.
- DEVSEL_ never asserted, DEVSEL_TIMEOUT=5 -> err_flags[3] set 5 clocks after DATA entry, bus_state back to IDLE, txn_count unchanged.
- FRAME_ rises with IRDY_ high, plus TRDY_ low while DEVSEL_ high in the same cycle -> err_flags=6'b000011, err_count incremented by 1 only. With CHECK_EN=6'b111110 -> flag 0 stays clear.
- Saturation: CNT_WIDTH=4, 20 single transactions -> txn_count=4'hF. Then clr -> 0 next cycle. reset_ low mid-burst -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/pci_mon_pkg.sv
// pci_mon_pkg
//   Shared definitions for the PCI protocol monitor.
//   bus_state_e : bus phase as reported on bus_state (IDLE/ADDR/DATA/LAST)
//   CHK_*       : bit index of each protocol check in err_flags / CHECK_EN
//   NUM_CHECKS  : width of err_flags and CHECK_EN
package pci_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      LAST = 2'd3
   } bus_state_e;

   localparam int CHK_FRM_IRDY    = 0;  // FRAME_ released while IRDY_ not asserted
   localparam int CHK_TRDY_DEVSEL = 1;  // TRDY_ asserted without DEVSEL_
   localparam int CHK_CBE_STABLE  = 2;  // byte enables changed during a wait state
   localparam int CHK_DEVSEL_TO   = 3;  // no target claimed the cycle (master abort)
   localparam int CHK_IRDY_DROP   = 4;  // IRDY_ withdrawn before the data transfer
   localparam int CHK_BACK2BACK   = 5;  // new address phase with no idle cycle
   localparam int NUM_CHECKS      = 6;

endpackage

// File: rtl/pci_protocol_monitor_if.sv
// pci_protocol_monitor_if
//   PCI bus signals observed by the monitor.
//   FRAME_/IRDY_/TRDY_/DEVSEL_ : active-low handshake
//   C_BE_                      : command / byte enables (AD_WIDTH/8 bits)
//   AD                         : address / data
//   master : drives the bus (bus model, testbench)
//   slave  : observes the bus (the monitor)
interface pci_protocol_monitor_if #(
   parameter int AD_WIDTH = 32
);
   localparam int CBE_WIDTH = AD_WIDTH / 8;

   logic                 FRAME_;
   logic                 IRDY_;
   logic                 TRDY_;
   logic                 DEVSEL_;
   logic [CBE_WIDTH-1:0] C_BE_;
   logic [AD_WIDTH-1:0]  AD;

   modport master (output FRAME_, IRDY_, TRDY_, DEVSEL_, C_BE_, AD);
   modport slave  (input  FRAME_, IRDY_, TRDY_, DEVSEL_, C_BE_, AD);
endinterface

// File: rtl/pci_mon_sat_counter.sv
// pci_mon_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk, reset_ : clock, asynchronous active-low reset
//   inc         : add one this cycle (ignored once saturated)
//   clr         : synchronous clear, overrides inc
//   count       : current value
module pci_mon_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pci_protocol_monitor.sv
// pci_protocol_monitor
//   Passive PCI bus monitor: tracks bus phases and flags protocol violations.
//   clk, reset_ : bus clock (posedge sampling), asynchronous active-low reset
//   bus         : observed PCI signals (slave modport)
//   clr         : synchronous clear of flags, pulse and counters (FSM untouched)
//   bus_state   : current phase IDLE/ADDR/DATA/LAST
//   err_flags   : sticky per-check violation flags
//   err_pulse   : one-cycle pulse for any enabled violation
//   err_count   : cycles with at least one enabled violation (saturating)
//   txn_count   : completed transactions (saturating)
//   data_count  : data transfers in DATA/LAST (saturating)
//   last_addr   : AD at the most recent address phase
//   last_cmd    : C_BE_ at the most recent address phase
module pci_protocol_monitor
   import pci_mon_pkg::*;
#(
   parameter int                    AD_WIDTH       = 32,
   parameter int                    CBE_WIDTH      = AD_WIDTH / 8,
   parameter int                    DEVSEL_TIMEOUT = 5,
   parameter logic [NUM_CHECKS-1:0] CHECK_EN       = 6'b111111,
   parameter int                    CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset_,
   pci_protocol_monitor_if.slave bus,
   input  logic                  clr,
   output logic [1:0]            bus_state,
   output logic [NUM_CHECKS-1:0] err_flags,
   output logic                  err_pulse,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  txn_count,
   output logic [CNT_WIDTH-1:0]  data_count,
   output logic [AD_WIDTH-1:0]   last_addr,
   output logic [CBE_WIDTH-1:0]  last_cmd
);

   localparam logic [4:0] TO_LIMIT = 5'(DEVSEL_TIMEOUT);

   bus_state_e            state_q, state_d;
   logic                  frame_q, irdy_q, trdy_q;
   logic [CBE_WIDTH-1:0]  cbe_q;
   logic [3:0]            tcnt_q;
   logic                  seen_q;

   logic                  fell_frame, rose_frame, xfer, in_dl, wait_prev, timeout;
   logic                  capture, txn_done, any_err;
   logic [NUM_CHECKS-1:0] fired, fired_en;

   always_comb begin
      fell_frame = frame_q & ~bus.FRAME_;
      rose_frame = ~frame_q & bus.FRAME_;
      xfer       = ~bus.IRDY_ & ~bus.TRDY_;
      in_dl      = (state_q == DATA) || (state_q == LAST);
      // previous sample was a master-ready, target-not-ready wait state
      wait_prev  = ~irdy_q & trdy_q;
      // tcnt_q counts the DEVSEL_-high samples already seen; this sample would be the next one
      timeout    = in_dl & bus.DEVSEL_ & ~seen_q & ((5'(tcnt_q) + 5'd1) == TO_LIMIT);
   end

   always_comb begin
      fired                  = '0;
      fired[CHK_FRM_IRDY]    = rose_frame & bus.IRDY_;
      fired[CHK_TRDY_DEVSEL] = ~bus.TRDY_ & bus.DEVSEL_;
      fired[CHK_CBE_STABLE]  = in_dl & wait_prev & (bus.C_BE_ != cbe_q);
      fired[CHK_DEVSEL_TO]   = timeout;
      fired[CHK_IRDY_DROP]   = in_dl & wait_prev & bus.IRDY_;
      fired[CHK_BACK2BACK]   = in_dl & fell_frame;
      fired_en               = fired & CHECK_EN;
      any_err                = |fired_en;
   end

   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      txn_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fell_frame) begin
               state_d = ADDR;
               capture = 1'b1;
            end
         end
         ADDR: state_d = DATA;
         DATA, LAST: begin
            if (fell_frame) begin
               state_d = ADDR;
               capture = 1'b1;
            end else if (timeout) begin
               state_d = IDLE;
            end else if ((state_q == DATA) && bus.FRAME_) begin
               state_d = LAST;
            end else if ((state_q == LAST) && bus.FRAME_ && xfer) begin
               state_d  = IDLE;
               txn_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         frame_q   <= 1'b1;
         irdy_q    <= 1'b1;
         trdy_q    <= 1'b1;
         cbe_q     <= '0;
         tcnt_q    <= '0;
         seen_q    <= 1'b0;
         last_addr <= '0;
         last_cmd  <= '0;
         err_flags <= '0;
         err_pulse <= 1'b0;
      end else begin
         frame_q <= bus.FRAME_;
         irdy_q  <= bus.IRDY_;
         trdy_q  <= bus.TRDY_;
         cbe_q   <= bus.C_BE_;

         // DEVSEL_ asserted at any point from the address phase on ends the timeout watch
         if (state_q == ADDR) begin
            tcnt_q <= '0;
            seen_q <= ~bus.DEVSEL_;
         end else if (in_dl) begin
            if (!bus.DEVSEL_)                   seen_q <= 1'b1;
            else if (!seen_q && tcnt_q != '1) tcnt_q <= tcnt_q + 4'd1;
         end

         if (capture) begin
            last_addr <= bus.AD;
            last_cmd  <= bus.C_BE_;
         end

         if (clr) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
         end else begin
            err_flags <= err_flags | fired_en;
            err_pulse <= any_err;
         end
      end
   end

   assign bus_state = state_q;

   pci_mon_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk(clk), .reset_(reset_), .inc(any_err), .clr(clr), .count(err_count)
   );

   pci_mon_sat_counter #(.WIDTH(CNT_WIDTH)) u_txn_cnt (
      .clk(clk), .reset_(reset_), .inc(txn_done), .clr(clr), .count(txn_count)
   );

   pci_mon_sat_counter #(.WIDTH(CNT_WIDTH)) u_data_cnt (
      .clk(clk), .reset_(reset_), .inc(in_dl & xfer), .clr(clr), .count(data_count)
   );

endmodule

// File: tb/tb_pci_protocol_monitor.sv
// tb_pci_protocol_monitor
//   Drives a PCI bus into two monitors (default configuration, and one with
//   check 0 masked and 4-bit counters) and compares every output each cycle
//   against a transaction-level reference model, plus directed sequences.
module tb_pci_protocol_monitor;

   localparam int TIMEOUT = 5;

   logic clk = 1'b0;
   logic reset_ = 1'b1;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   pci_protocol_monitor_if #(.AD_WIDTH(32)) bus ();

   logic [1:0]  st_a, st_b;
   logic [5:0]  fl_a, fl_b;
   logic        pu_a, pu_b;
   logic [15:0] ec_a, tc_a, dc_a;
   logic [3:0]  ec_b, tc_b, dc_b;
   logic [31:0] la_a, la_b;
   logic [3:0]  lc_a, lc_b;

   pci_protocol_monitor #(
      .AD_WIDTH(32), .DEVSEL_TIMEOUT(TIMEOUT), .CHECK_EN(6'b111111), .CNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .reset_(reset_), .bus(bus), .clr(clr),
      .bus_state(st_a), .err_flags(fl_a), .err_pulse(pu_a), .err_count(ec_a),
      .txn_count(tc_a), .data_count(dc_a), .last_addr(la_a), .last_cmd(lc_a)
   );

   pci_protocol_monitor #(
      .AD_WIDTH(32), .DEVSEL_TIMEOUT(TIMEOUT), .CHECK_EN(6'b111110), .CNT_WIDTH(4)
   ) dut_b (
      .clk(clk), .reset_(reset_), .bus(bus), .clr(clr),
      .bus_state(st_b), .err_flags(fl_b), .err_pulse(pu_b), .err_count(ec_b),
      .txn_count(tc_b), .data_count(dc_b), .last_addr(la_b), .last_cmd(lc_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Phase numbers follow the bus_state values; the DEVSEL_ watch is kept as
   // "samples spent in the data phases" plus "DEVSEL_ seen since the address".
   int          m_ph;
   bit          m_pf, m_pi, m_pt;
   logic [3:0]  m_pcbe;
   bit          m_seen;
   int          m_dl_samples;
   logic [31:0] m_addr;
   logic [3:0]  m_cmd;
   bit [5:0]    m_flags [2];
   bit          m_pulse [2];
   int          m_err [2], m_txn [2], m_data [2];
   bit [5:0]    m_mask [2];
   int          m_max [2];

   task automatic model_reset();
      m_ph = 0; m_pf = 1; m_pi = 1; m_pt = 1; m_pcbe = '0;
      m_seen = 0; m_dl_samples = 0; m_addr = '0; m_cmd = '0;
      for (int k = 0; k < 2; k++) begin
         m_flags[k] = '0; m_pulse[k] = 0; m_err[k] = 0; m_txn[k] = 0; m_data[k] = 0;
      end
   endtask

   task automatic model_step(input bit f, i, t, d, input logic [3:0] cbe,
                             input logic [31:0] ad, input bit c);
      bit fell, rose, xf, indl, wprev, devsel_ok, timeout, done;
      bit [5:0] fired, en;
      fell      = m_pf && !f;
      rose      = !m_pf && f;
      xf        = !i && !t;
      indl      = (m_ph == 2) || (m_ph == 3);
      wprev     = !m_pi && m_pt;
      devsel_ok = m_seen || !d;
      timeout   = indl && !devsel_ok && (m_dl_samples + 1 == TIMEOUT);
      fired    = '0;
      fired[0] = rose && i;
      fired[1] = !t && d;
      fired[2] = indl && wprev && (cbe != m_pcbe);
      fired[3] = timeout;
      fired[4] = indl && wprev && i;
      fired[5] = indl && fell;
      done = 0;
      if (m_ph == 1) begin
         m_dl_samples = 0; m_seen = !d;
      end else if (indl) begin
         m_dl_samples++; m_seen = devsel_ok;
      end
      if (m_ph == 0) begin
         if (fell) begin m_ph = 1; m_addr = ad; m_cmd = cbe; end
      end else if (m_ph == 1) begin
         m_ph = 2;
      end else begin
         if (fell) begin m_ph = 1; m_addr = ad; m_cmd = cbe; end
         else if (timeout) m_ph = 0;
         else if (m_ph == 2 && f) m_ph = 3;
         else if (m_ph == 3 && f && xf) begin m_ph = 0; done = 1; end
      end
      for (int k = 0; k < 2; k++) begin
         en = fired & m_mask[k];
         if (c) begin
            m_flags[k] = '0; m_pulse[k] = 0; m_err[k] = 0; m_txn[k] = 0; m_data[k] = 0;
         end else begin
            m_flags[k] = m_flags[k] | en;
            m_pulse[k] = |en;
            if (|en && m_err[k] < m_max[k]) m_err[k]++;
            if (done && m_txn[k] < m_max[k]) m_txn[k]++;
            if (indl && xf && m_data[k] < m_max[k]) m_data[k]++;
         end
      end
      m_pf = f; m_pi = i; m_pt = t; m_pcbe = cbe;
   endtask

   task automatic compare_model();
      chk("A.bus_state",  64'(st_a), 64'(m_ph));
      chk("A.err_flags",  64'(fl_a), 64'(m_flags[0]));
      chk("A.err_pulse",  64'(pu_a), 64'(m_pulse[0]));
      chk("A.err_count",  64'(ec_a), 64'(m_err[0]));
      chk("A.txn_count",  64'(tc_a), 64'(m_txn[0]));
      chk("A.data_count", 64'(dc_a), 64'(m_data[0]));
      chk("A.last_addr",  64'(la_a), 64'(m_addr));
      chk("A.last_cmd",   64'(lc_a), 64'(m_cmd));
      chk("B.bus_state",  64'(st_b), 64'(m_ph));
      chk("B.err_flags",  64'(fl_b), 64'(m_flags[1]));
      chk("B.err_pulse",  64'(pu_b), 64'(m_pulse[1]));
      chk("B.err_count",  64'(ec_b), 64'(m_err[1]));
      chk("B.txn_count",  64'(tc_b), 64'(m_txn[1]));
      chk("B.data_count", 64'(dc_b), 64'(m_data[1]));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".A.state"}, 64'(st_a), 64'd0);
      chk({tag, ".A.flags"}, 64'(fl_a), 64'd0);
      chk({tag, ".A.pulse"}, 64'(pu_a), 64'd0);
      chk({tag, ".A.err"},   64'(ec_a), 64'd0);
      chk({tag, ".A.txn"},   64'(tc_a), 64'd0);
      chk({tag, ".A.data"},  64'(dc_a), 64'd0);
      chk({tag, ".A.addr"},  64'(la_a), 64'd0);
      chk({tag, ".A.cmd"},   64'(lc_a), 64'd0);
      chk({tag, ".B.txn"},   64'(tc_b), 64'd0);
      chk({tag, ".B.data"},  64'(dc_b), 64'd0);
   endtask

   // apply one bus cycle, advance the model on the same edge, compare 1 time unit later
   task automatic step(input bit f, i, t, d, input logic [3:0] cbe,
                       input logic [31:0] ad, input bit c);
      bus.FRAME_ = f; bus.IRDY_ = i; bus.TRDY_ = t; bus.DEVSEL_ = d;
      bus.C_BE_ = cbe; bus.AD = ad; clr = c;
      @(posedge clk);
      model_step(f, i, t, d, cbe, ad, c);
      #1;
      compare_model();
   endtask

   task automatic set_idle();
      bus.FRAME_ = 1; bus.IRDY_ = 1; bus.TRDY_ = 1; bus.DEVSEL_ = 1;
      bus.C_BE_ = '0; bus.AD = '0; clr = 0;
   endtask

   task automatic do_reset();
      set_idle();
      reset_ = 1'b0;
      #2;
      model_reset();
      chk_zero("reset");
      @(negedge clk);
      reset_ = 1'b1;
   endtask

   // ---------------- single-write vector table ----------------
   typedef struct {
      bit          f, i, t, d;
      logic [3:0]  cbe;
      logic [31:0] ad;
      logic [1:0]  e_state;
      int          e_data;
      int          e_txn;
   } vec_t;

   vec_t tbl [5];

   task automatic run_single(input bit check_rows);
      for (int r = 0; r < 5; r++) begin
         step(tbl[r].f, tbl[r].i, tbl[r].t, tbl[r].d, tbl[r].cbe, tbl[r].ad, 1'b0);
         if (check_rows) begin
            chk($sformatf("single[%0d].state", r), 64'(st_a), 64'(tbl[r].e_state));
            chk($sformatf("single[%0d].data", r),  64'(dc_a), 64'(tbl[r].e_data));
            chk($sformatf("single[%0d].txn", r),   64'(tc_a), 64'(tbl[r].e_txn));
         end
      end
   endtask

   // burst of 4 data transfers with 2 wait states; optional C_BE_ change in the first wait
   task automatic run_burst(input bit change_cbe);
      logic [3:0] be2;
      be2 = change_cbe ? 4'h3 : 4'h0;
      step(0, 1, 1, 1, 4'h7, 32'h2000_0000, 0);
      step(0, 0, 1, 0, 4'h0, 32'h0, 0);
      step(0, 0, 0, 0, 4'h0, 32'h0, 0);
      step(0, 0, 1, 0, 4'h0, 32'h0, 0);
      step(0, 0, 0, 0, be2,  32'h0, 0);
      chk("burst.pulse_on", 64'(pu_a), 64'(change_cbe));
      step(0, 0, 0, 0, be2,  32'h0, 0);
      chk("burst.pulse_off", 64'(pu_a), 64'd0);
      step(1, 0, 1, 0, be2,  32'h0, 0);
      step(1, 0, 0, 0, be2,  32'h0, 0);
      step(1, 1, 1, 1, be2,  32'h0, 0);
      chk("burst.data",  64'(dc_a), 64'd4);
      chk("burst.txn",   64'(tc_a), 64'd1);
      chk("burst.flags", 64'(fl_a), change_cbe ? 64'h4 : 64'h0);
      chk("burst.err",   64'(ec_a), 64'(change_cbe));
   endtask

   initial begin
      bit         rf, ri, rt, rd, rc, dead;
      logic [3:0] rcbe;

      m_mask[0] = 6'h3F; m_mask[1] = 6'h3E;
      m_max[0]  = 65535; m_max[1]  = 15;

      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 32'h1000_0040, 2'd1, 0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 32'h0,         2'd2, 0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 32'h0,         2'd3, 0, 0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 32'h0,         2'd0, 1, 1};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 32'h0,         2'd0, 1, 1};

      #1;
      do_reset();

      // single write
      run_single(1'b1);
      chk("single.addr",  64'(la_a), 64'h1000_0040);
      chk("single.cmd",   64'(lc_a), 64'h7);
      chk("single.flags", 64'(fl_a), 64'h0);

      // bursts
      do_reset();
      run_burst(1'b0);
      do_reset();
      run_burst(1'b1);

      // DEVSEL_ never asserted
      do_reset();
      step(0, 1, 1, 1, 4'h6, 32'h5000_0000, 0);
      step(1, 0, 1, 1, 4'h6, 32'h0, 0);
      for (int n = 0; n < TIMEOUT - 1; n++) step(1, 0, 1, 1, 4'h6, 32'h0, 0);
      chk("timeout.before_state", 64'(st_a), 64'd3);
      chk("timeout.before_flags", 64'(fl_a), 64'h0);
      step(1, 0, 1, 1, 4'h6, 32'h0, 0);
      chk("timeout.flags", 64'(fl_a), 64'h8);
      chk("timeout.state", 64'(st_a), 64'd0);
      chk("timeout.txn",   64'(tc_a), 64'd0);
      step(1, 1, 1, 1, 4'h6, 32'h0, 0);

      // checks 0 and 1 in the same sample, with and without check 0 enabled
      do_reset();
      step(0, 1, 1, 1, 4'h7, 32'h6000_0000, 0);
      step(1, 1, 0, 1, 4'h7, 32'h0, 0);
      chk("chk01.A.flags", 64'(fl_a), 64'h3);
      chk("chk01.A.err",   64'(ec_a), 64'd1);
      chk("chk01.B.flags", 64'(fl_b), 64'h2);
      chk("chk01.B.err",   64'(ec_b), 64'd1);

      // clr coinciding with a violation
      do_reset();
      step(0, 1, 1, 1, 4'h7, 32'h6000_0000, 0);
      step(1, 1, 0, 1, 4'h7, 32'h0, 1);
      chk("clrwin.flags", 64'(fl_a), 64'h0);
      chk("clrwin.pulse", 64'(pu_a), 64'd0);
      chk("clrwin.err",   64'(ec_a), 64'd0);

      // saturation of the 4-bit counters, then clear
      do_reset();
      for (int n = 0; n < 20; n++) run_single(1'b0);
      chk("sat.B.txn",  64'(tc_b), 64'hF);
      chk("sat.B.data", 64'(dc_b), 64'hF);
      chk("sat.A.txn",  64'(tc_a), 64'd20);
      step(1, 1, 1, 1, 4'h0, 32'h0, 1);
      chk("clr.A.txn",  64'(tc_a), 64'd0);
      chk("clr.B.txn",  64'(tc_b), 64'd0);

      // asynchronous reset in the middle of a burst
      step(0, 1, 1, 1, 4'h7, 32'h3000_0000, 0);
      step(0, 0, 1, 0, 4'h0, 32'h0, 0);
      step(0, 0, 0, 0, 4'h0, 32'h0, 0);
      chk("async.pre_data", 64'(dc_a), 64'd1);
      #2 reset_ = 1'b0;
      #1 chk_zero("async");
      model_reset();
      set_idle();
      @(negedge clk);
      reset_ = 1'b1;
      run_single(1'b0);
      chk("post_reset.txn",  64'(tc_a), 64'd1);
      chk("post_reset.addr", 64'(la_a), 64'h1000_0040);

      // randomized traffic
      do_reset();
      rf = 1; dead = 0; rcbe = '0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) dead = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 4) == 0) rf = ~rf;
         ri = ($urandom_range(0, 3) == 0);
         rt = 1'($urandom_range(0, 1));
         rd = dead ? 1'b1 : ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) rcbe = 4'($urandom);
         rc = ($urandom_range(0, 39) == 0);
         step(rf, ri, rt, rd, rcbe, $urandom, rc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
